floattofixed: RTL and testbench

//  Converts IEEE-754 single-precision floats into signed Q2.26 fixed point (28-bit two's complement).
//  It is the return path of the fixed-to-float converter, used where float results re-enter the fixed datapath.

---
 rtl/floattofixed_pkg.sv | 32 +++
 rtl/fp_unpack.sv | 54 +++++
 rtl/floattofixed.sv | 171 +++++++++++++++++
 tb/tb_floattofixed.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/floattofixed_pkg.sv
// ============================================================================
// Module : floattofixed_pkg
// Brief  : Shared constants, float-field widths and class encoding for the
//          float-to-Q2.26 converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package floattofixed_pkg;

    localparam int DEFAULT_FIXED_W = 28;
    localparam int DEFAULT_FRAC_W  = 26;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_SIG_W  = FP_MANT_W + 1;

    localparam logic [DEFAULT_FIXED_W-1:0] FX_MAX = {1'b0, {(DEFAULT_FIXED_W-1){1'b1}}};
    localparam logic [DEFAULT_FIXED_W-1:0] FX_MIN = {1'b1, {(DEFAULT_FIXED_W-1){1'b0}}};

    typedef enum logic [2:0] {
        CLS_NORM = 3'd0,
        CLS_ZERO = 3'd1,
        CLS_BIG  = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_class_t;

endpackage

`default_nettype wire

// File: rtl/fp_unpack.sv
// ============================================================================
// Module : fp_unpack
// Brief  : Combinational split of a single-precision float into sign,
//          significand, class and alignment shift for the fixed-point target.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_unpack
    import floattofixed_pkg::*;
#(
    parameter int FIXED_W = DEFAULT_FIXED_W,
    parameter int FRAC_W  = DEFAULT_FRAC_W
) (
    input  logic [31:0]          i_float,
    output logic                 o_sign,
    output fp_class_t            o_cls,
    output logic signed [8:0]    o_sh,
    output logic [FP_SIG_W-1:0]  o_sig,
    output logic                 o_negtwo
);

    // Largest unbiased exponent that still fits the integer part is one below this.
    localparam int c_big_e = FIXED_W - 1 - FRAC_W;

    logic [FP_EXP_W-1:0]  w_exp;
    logic [FP_MANT_W-1:0] w_mant;
    logic signed [8:0]    w_e;

    assign w_exp  = i_float[30:23];
    assign w_mant = i_float[22:0];
    assign w_e    = $signed({1'b0, w_exp}) - $signed(9'(FP_BIAS));

    assign o_sign = i_float[31];
    assign o_sig  = {1'b1, w_mant};
    assign o_sh   = 9'(int'(w_e) + FRAC_W - FP_MANT_W);

    // Exactly the most negative representable value: saturates without overflow.
    assign o_negtwo = i_float[31] && (int'(w_e) == c_big_e) && (w_mant == '0);

    always_comb begin
        o_cls = CLS_NORM;
        if (w_exp == '0) begin
            o_cls = CLS_ZERO;
        end else if (w_exp == {FP_EXP_W{1'b1}}) begin
            o_cls = (w_mant != '0) ? CLS_NAN : CLS_INF;
        end else if (int'(w_e) >= c_big_e) begin
            o_cls = CLS_BIG;
        end
    end

endmodule

`default_nettype wire

// File: rtl/floattofixed.sv
// ============================================================================
// Module : floattofixed
// Brief  : Three-stage float32 to signed Q2.26 converter with clock enable,
//          valid tracking, truncation toward zero and saturation flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module floattofixed
    import floattofixed_pkg::*;
#(
    parameter int FIXED_W = DEFAULT_FIXED_W,
    parameter int FRAC_W  = DEFAULT_FRAC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic               in_valid,
    input  logic [31:0]        floatin,
    output logic               out_valid,
    output logic [FIXED_W-1:0] fixedout,
    output logic               ovf,
    output logic               nan
);

    localparam int c_mag_w   = FIXED_W - 1;
    localparam int c_max_lsh = c_mag_w - FP_SIG_W;
    localparam logic [FIXED_W-1:0] c_fx_max = {1'b0, {(FIXED_W-1){1'b1}}};
    localparam logic [FIXED_W-1:0] c_fx_min = {1'b1, {(FIXED_W-1){1'b0}}};

    // ---------------- S1: unpack / classify ----------------
    logic                w_sign;
    fp_class_t           w_cls;
    logic signed [8:0]   w_sh;
    logic [FP_SIG_W-1:0] w_sig;
    logic                w_negtwo;

    fp_unpack #(
        .FIXED_W (FIXED_W),
        .FRAC_W  (FRAC_W)
    ) u_unpack (
        .i_float  (floatin),
        .o_sign   (w_sign),
        .o_cls    (w_cls),
        .o_sh     (w_sh),
        .o_sig    (w_sig),
        .o_negtwo (w_negtwo)
    );

    logic                r1_valid;
    logic                r1_sign;
    fp_class_t           r1_cls;
    logic signed [8:0]   r1_sh;
    logic [FP_SIG_W-1:0] r1_sig;
    logic                r1_negtwo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid  <= 1'b0;
            r1_sign   <= 1'b0;
            r1_cls    <= CLS_ZERO;
            r1_sh     <= '0;
            r1_sig    <= '0;
            r1_negtwo <= 1'b0;
        end else if (clken) begin
            r1_valid  <= in_valid;
            r1_sign   <= w_sign;
            r1_cls    <= w_cls;
            r1_sh     <= w_sh;
            r1_sig    <= w_sig;
            r1_negtwo <= w_negtwo;
        end
    end

    // ---------------- S2: align ----------------
    logic [c_mag_w-1:0] w_sig_ext;
    logic [8:0]         w_ramt;
    logic [c_mag_w-1:0] w_mag;

    assign w_sig_ext = c_mag_w'(r1_sig);
    assign w_ramt    = 9'(-r1_sh);

    // Out-of-range shift counts resolve to zero rather than wrapping.
    always_comb begin
        w_mag = '0;
        if (!r1_sh[8]) begin
            if (int'(r1_sh) <= c_max_lsh) begin
                w_mag = w_sig_ext << r1_sh;
            end
        end else if (w_ramt < 9'(FP_SIG_W)) begin
            w_mag = w_sig_ext >> w_ramt;
        end
    end

    logic               r2_valid;
    logic               r2_sign;
    fp_class_t          r2_cls;
    logic               r2_negtwo;
    logic [c_mag_w-1:0] r2_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_cls    <= CLS_ZERO;
            r2_negtwo <= 1'b0;
            r2_mag    <= '0;
        end else if (clken) begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_cls    <= r1_cls;
            r2_negtwo <= r1_negtwo;
            r2_mag    <= w_mag;
        end
    end

    // ---------------- S3: sign / saturate ----------------
    logic [FIXED_W-1:0] w_mag_ext;
    logic [FIXED_W-1:0] w_fx;
    logic               w_ovf;
    logic               w_nan;

    assign w_mag_ext = {1'b0, r2_mag};

    always_comb begin
        w_fx  = '0;
        w_ovf = 1'b0;
        w_nan = 1'b0;
        case (r2_cls)
            CLS_NORM: w_fx = r2_sign ? -w_mag_ext : w_mag_ext;
            CLS_ZERO: w_fx = '0;
            CLS_BIG, CLS_INF: begin
                if (r2_negtwo) begin
                    w_fx = c_fx_min;
                end else begin
                    w_fx  = r2_sign ? c_fx_min : c_fx_max;
                    w_ovf = 1'b1;
                end
            end
            CLS_NAN:  w_nan = 1'b1;
            default:  w_fx = '0;
        endcase
    end

    logic               r3_valid;
    logic [FIXED_W-1:0] r3_fx;
    logic               r3_ovf;
    logic               r3_nan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r3_valid <= 1'b0;
            r3_fx    <= '0;
            r3_ovf   <= 1'b0;
            r3_nan   <= 1'b0;
        end else if (clken) begin
            r3_valid <= r2_valid;
            r3_fx    <= w_fx;
            r3_ovf   <= w_ovf;
            r3_nan   <= w_nan;
        end
    end

    assign out_valid = r3_valid;
    assign fixedout  = r3_fx;
    assign ovf       = r3_ovf;
    assign nan       = r3_nan;

endmodule

`default_nettype wire

// File: tb/tb_floattofixed.sv
// ============================================================================
// Module : tb_floattofixed
// Brief  : Self-checking bench for floattofixed: directed vectors, stalled
//          stream against a real-valued reference, and mid-stream reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_floattofixed;
    import floattofixed_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        in_valid;
    logic [31:0] floatin;
    logic        out_valid;
    logic [27:0] fixedout;
    logic        ovf;
    logic        nan;

    floattofixed dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .in_valid  (in_valid),
        .floatin   (floatin),
        .out_valid (out_valid),
        .fixedout  (fixedout),
        .ovf       (ovf),
        .nan       (nan)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Real-valued reference: scale by 2^26, truncate toward zero, saturate.
    function automatic void ref_model(input logic [31:0] f, output logic [27:0] fx,
                                      output logic o, output logic n);
        real r;
        int  e;
        fx = '0; o = 1'b0; n = 1'b0;
        e  = int'(f[30:23]);
        if (e == 255) begin
            if (f[22:0] != 0) n = 1'b1;
            else begin o = 1'b1; fx = f[31] ? FX_MIN : FX_MAX; end
            return;
        end
        if (e == 0) return;
        r = (8388608.0 + real'(int'(f[22:0]))) * (2.0 ** (e - 127 - 23 + 26));
        if (f[31]) r = -r;
        if (r >= 134217728.0) begin o = 1'b1; fx = FX_MAX; end
        else if (r < -134217728.0) begin o = 1'b1; fx = FX_MIN; end
        else fx = 28'($rtoi(r));
    endfunction

    typedef struct {
        logic [31:0] f;
        logic [27:0] fx;
        logic        o;
        logic        n;
    } vec_t;

    typedef struct {
        logic [27:0] fx;
        logic        o;
        logic        n;
    } exp_t;

    // Stream monitor state
    bit    mon_en = 0;
    logic  last_ce = 1'b0;
    exp_t  q[$];
    exp_t  last_exp;
    bit    have_last = 0;
    int    pushed = 0;
    int    popped = 0;

    always @(posedge clk) last_ce = clken;

    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            if (last_ce) begin
                if (q.size() == 0) begin
                    check("stream_extra_output", 32'd1, 32'd0);
                end else begin
                    last_exp = q.pop_front();
                    popped++;
                    have_last = 1;
                    check("stream_fx", fixedout, last_exp.fx);
                    check("stream_ovf", ovf, last_exp.o);
                    check("stream_nan", nan, last_exp.n);
                end
            end else if (have_last) begin
                check("stall_hold_fx", fixedout, last_exp.fx);
            end
        end
    end

    task automatic run_one(input logic [31:0] f, output logic [27:0] fx,
                           output logic o, output logic n, output int lat);
        @(negedge clk);
        floatin  = f;
        in_valid = 1'b1;
        clken    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        floatin  = 32'hDEADBEEF;
        lat = -1; fx = '0; o = 1'b0; n = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (out_valid) begin
                lat = k; fx = fixedout; o = ovf; n = nan;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[15];
        logic [27:0] gfx, efx;
        logic        go, gn, eo, en;
        int          lat;
        bit          quiet;

        vecs[0]  = '{32'h3F800000, 28'h4000000, 1'b0, 1'b0};
        vecs[1]  = '{32'hBF800000, 28'hC000000, 1'b0, 1'b0};
        vecs[2]  = '{32'h3F000000, 28'h2000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h80000000, 28'h0000000, 1'b0, 1'b0};
        vecs[4]  = '{32'h32800000, 28'h0000001, 1'b0, 1'b0};
        vecs[5]  = '{32'h32C00000, 28'h0000001, 1'b0, 1'b0};
        vecs[6]  = '{32'hB2C00000, 28'hFFFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{32'h32000000, 28'h0000000, 1'b0, 1'b0};
        vecs[8]  = '{32'h40400000, 28'h7FFFFFF, 1'b1, 1'b0};
        vecs[9]  = '{32'hC0400000, 28'h8000000, 1'b1, 1'b0};
        vecs[10] = '{32'hC0000000, 28'h8000000, 1'b0, 1'b0};
        vecs[11] = '{32'h7F800000, 28'h7FFFFFF, 1'b1, 1'b0};
        vecs[12] = '{32'h7FC00000, 28'h0000000, 1'b0, 1'b1};
        vecs[13] = '{32'h00000001, 28'h0000000, 1'b0, 1'b0};
        vecs[14] = '{32'h40000000, 28'h7FFFFFF, 1'b1, 1'b0};

        reset = 1'b1; clken = 1'b0; in_valid = 1'b0; floatin = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_fixedout", fixedout, 0);
        check("reset_ovf", ovf, 0);
        check("reset_nan", nan, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_one(vecs[i].f, gfx, go, gn, lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_fx(%h)", i, vecs[i].f), gfx, vecs[i].fx);
            check($sformatf("vec%0d_ovf", i), go, vecs[i].o);
            check($sformatf("vec%0d_nan", i), gn, vecs[i].n);
        end

        // Back-to-back random stream with a 5-cycle clken stall in the middle
        repeat (4) @(negedge clk);
        mon_en = 1;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] f;
            exp_t        e;
            @(negedge clk);
            if (i == 10) begin
                clken    = 1'b0;
                in_valid = 1'b1;
                floatin  = 32'h3F800000;
                repeat (5) @(negedge clk);
            end
            f = {1'($urandom_range(0, 1)), 8'($urandom_range(95, 129)), 23'($urandom)};
            ref_model(f, efx, eo, en);
            e.fx = efx; e.o = eo; e.n = en;
            q.push_back(e);
            pushed++;
            clken    = 1'b1;
            in_valid = 1'b1;
            floatin  = f;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        check("stream_drained", q.size(), 0);
        check("stream_count", popped, pushed);
        repeat (3) @(negedge clk);
        mon_en = 0;

        // Mid-stream asynchronous reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clken = 1'b1; in_valid = 1'b1; floatin = 32'h3F800000;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_fx", fixedout, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quiet = 1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) quiet = 0;
        end
        check("post_reset_quiet", quiet, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
